// File: rtl/output_display_driver.sv
// 8-bit value -> 4-digit multiplexed 7-seg decimal display (sequential double-dabble + scanner).
// Optional two's-complement display with minus sign: define SIGNED_DISPLAY_EN.
module output_display_driver #(
  parameter logic [15:0] REFRESH_DIV    = 16'd50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] out_val,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] anode,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  localparam logic [3:0] D_BLANK = 4'd10;
  localparam logic [3:0] D_MINUS = 4'd11;

  state_t      state_q, state_d;
  logic [2:0]  iter_q, iter_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic        sign_q, sign_d;
  logic [7:0]  pend_val_q, pend_val_d;
  logic        pend_vld_q, pend_vld_d;
  logic [11:0] disp_bcd_q, disp_bcd_d;
  logic        disp_sign_q, disp_sign_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  dig_q, dig_d;
  logic        busy_q, busy_d;

  logic [7:0]  start_raw, start_mag;
  logic        start_neg;
  logic [11:0] adj;
  logic [3:0]  dcode;
  logic [6:0]  seg_hi;
  logic [3:0]  an_hi;

  // A fresh load always beats an older pending value.
  always_comb begin
    start_raw = load ? out_val : pend_val_q;
`ifdef SIGNED_DISPLAY_EN
    start_mag = start_raw[7] ? (~start_raw + 8'd1) : start_raw;
    start_neg = start_raw[7];
`else
    start_mag = start_raw;
    start_neg = 1'b0;
`endif
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
  end

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    pend_val_d  = pend_val_q;
    pend_vld_d  = pend_vld_q;
    disp_bcd_d  = disp_bcd_q;
    disp_sign_d = disp_sign_q;
    case (state_q)
      IDLE: if (load) begin
        state_d = CONVERT;
        iter_d  = 3'd0;
        bin_d   = start_mag;
        bcd_d   = 12'd0;
        sign_d  = start_neg;
      end
      CONVERT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = COMMIT;
        if (load) begin
          pend_val_d = out_val;
          pend_vld_d = 1'b1;
        end
      end
      COMMIT: begin
        disp_bcd_d  = bcd_q;
        disp_sign_d = sign_q;
        pend_vld_d  = 1'b0;
        if (load || pend_vld_q) begin
          state_d = CONVERT;
          iter_d  = 3'd0;
          bin_d   = start_mag;
          bcd_d   = 12'd0;
          sign_d  = start_neg;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    if (cnt_q == REFRESH_DIV - 16'd1) begin
      cnt_d = 16'd0;
      dig_d = dig_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
      dig_d = dig_q;
    end
  end

  // Leading-zero blanking; ones digit is always lit.
  always_comb begin
    case (dig_q)
      2'd0:    dcode = disp_bcd_q[3:0];
      2'd1:    dcode = (disp_bcd_q[11:4] == 8'd0) ? D_BLANK : disp_bcd_q[7:4];
      2'd2:    dcode = (disp_bcd_q[11:8] == 4'd0) ? D_BLANK : disp_bcd_q[11:8];
      default: dcode = disp_sign_q ? D_MINUS : D_BLANK;
    endcase
    case (dcode)
      4'd0:    seg_hi = 7'h3F;
      4'd1:    seg_hi = 7'h06;
      4'd2:    seg_hi = 7'h5B;
      4'd3:    seg_hi = 7'h4F;
      4'd4:    seg_hi = 7'h66;
      4'd5:    seg_hi = 7'h6D;
      4'd6:    seg_hi = 7'h7D;
      4'd7:    seg_hi = 7'h07;
      4'd8:    seg_hi = 7'h7F;
      4'd9:    seg_hi = 7'h6F;
      D_MINUS: seg_hi = 7'h40;
      default: seg_hi = 7'h00;
    endcase
    an_hi = 4'b0001 << dig_q;
    seg   = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    anode = SEG_ACTIVE_LOW ? ~an_hi : an_hi;
    busy  = busy_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      iter_q      <= 3'd0;
      bin_q       <= 8'd0;
      bcd_q       <= 12'd0;
      sign_q      <= 1'b0;
      pend_val_q  <= 8'd0;
      pend_vld_q  <= 1'b0;
      disp_bcd_q  <= 12'd0;
      disp_sign_q <= 1'b0;
      cnt_q       <= 16'd0;
      dig_q       <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      pend_val_q  <= pend_val_d;
      pend_vld_q  <= pend_vld_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_sign_q <= disp_sign_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_output_display_driver.sv
// Bench for output_display_driver: directed steps plus random loads against a decimal display model.
module tb_output_display_driver;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] out_val = 8'd0;
  logic       load = 1'b0;
  logic [6:0] seg;
  logic [3:0] anode;
  logic       busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [7:0] disp_val = 8'd0;
  logic [7:0] last_val;

  output_display_driver #(.REFRESH_DIV(16'(DIV)), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .out_val(out_val), .load(load),
    .seg(seg), .anode(anode), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycles since reset release determine which digit should be lit.
  always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

  function automatic logic [6:0] pat(int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F; 11: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(logic [7:0] v, int idx);
    int mag, h, t, o, d;
    bit neg;
    mag = int'(v);
    neg = 1'b0;
`ifdef SIGNED_DISPLAY_EN
    if (v[7]) begin
      mag = 256 - int'(v);
      neg = 1'b1;
    end
`endif
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    case (idx)
      0: d = o;
      1: d = (h == 0 && t == 0) ? 10 : t;
      2: d = (h == 0) ? 10 : h;
      default: d = neg ? 11 : 10;
    endcase
    return ~pat(d);
  endfunction

  function automatic logic [3:0] exp_anode(int idx);
    logic [3:0] a;
    a = 4'b0001 << idx;
    return ~a;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(string tag);
    int idx;
    idx = (cyc / DIV) % 4;
    chk({tag, "_anode"}, 32'(anode), 32'(exp_anode(idx)));
    chk({tag, "_seg"}, 32'(seg), 32'(exp_seg(disp_val, idx)));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic scan(string tag, int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      chk_disp(tag);
      @(negedge clk);
    end
  endtask

  task automatic pulse_load(logic [7:0] v);
    out_val = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Load at edge N; busy over N..N+8 with old digits, new digits after N+9.
  task automatic load_timed(logic [7:0] v);
    @(negedge clk);
    pulse_load(v);
    for (int k = 0; k < 9; k++) begin
      chk("busy_conv", 32'(busy), 32'd1);
      chk_disp("disp_hold");
      @(negedge clk);
    end
    disp_val = v;
    chk("busy_done", 32'(busy), 32'd0);
    chk_disp("disp_new");
  endtask

  initial begin
    // 1: reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_anode", 32'(anode), 32'b1110);
    chk("rst_seg", 32'(seg), 32'b1000000);
    scan("rst_scan", 2 * DIV);

    // 2: 0x44 with exact latency
    load_timed(8'h44);
    scan("v44", 4 * DIV);

    // 3: extremes and a full scan cycle
    load_timed(8'hFF);
    scan("vff", 4 * DIV);
    load_timed(8'h00);
    scan("v00", 4 * DIV + 4);

    // 4: loads while busy, latest pending wins, busy continuous
    @(negedge clk);
    out_val = 8'h22;
    load = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 18; k++) begin
      if (k == 9)  disp_val = 8'h22;
      if (k == 18) disp_val = 8'h7B;
      chk("pend_busy", 32'(busy), 32'(k < 18));
      chk_disp("pend_disp");
      load = (k == 1 || k == 2);
      out_val = (k == 1) ? 8'h10 : 8'h7B;
      @(negedge clk);
    end
    scan("v7b", 4 * DIV);

    // 5: reset mid-conversion aborts with nothing committed
    @(negedge clk);
    pulse_load(8'h63);
    for (int k = 0; k < 3; k++) begin
      chk("abort_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    disp_val = 8'h00;
    for (int k = 0; k < 12; k++) begin
      chk("abort_idle", 32'(busy), 32'd0);
      chk_disp("abort_disp");
      @(negedge clk);
    end

    // 6: sign-relevant values (model decides signed vs unsigned rendering)
    load_timed(8'hFF);
    scan("s_ff", 4 * DIV);
    load_timed(8'h80);
    scan("s_80", 4 * DIV);
    load_timed(8'h7F);
    scan("s_7f", 4 * DIV);

    // random bursts: only the last value of each burst must end up displayed
    for (int r = 0; r < 25; r++) begin
      int nl;
      nl = $urandom_range(1, 3);
      last_val = 8'h00;
      for (int j = 0; j < nl; j++) begin
        last_val = 8'($urandom);
        pulse_load(last_val);
        repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      wait_idle();
      disp_val = last_val;
      scan("rand", 4 * DIV);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
